// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, result codes and ranking helper for the match referee
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FIGHT,
        ST_HOLD,
        ST_MATCH_OVER
    } state_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [1:0] HEALTH_KO = 2'd0;

    // Larger value wins for player 1 (a) or player 2 (b); a tie is a draw.
    function automatic logic [1:0] rank(input int a, input int b);
        if (a > b)
            return RES_P1;
        else if (a < b)
            return RES_P2;
        else
            return RES_DRAW;
    endfunction

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - loadable round down-counter with a last-tick flag
module round_timer #(
    parameter int W        = 7,
    parameter int LOAD_VAL = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Load takes priority over counting; otherwise hold.
    always_comb begin
        value_d = value_q;
        if (load)
            value_d = W'(LOAD_VAL);
        else if (en)
            value_d = value_q - W'(1);
    end

    // Counter register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst)
            value_q <= '0;
        else
            value_q <= value_d;
    end

    assign value = value_q;
    assign last  = (value_q == W'(1));

endmodule

// File: rtl/match_referee.sv
// rtl/match_referee.sv - round/match referee: KO and time-out detection, best-of-N scoring
module match_referee
    import game_pkg::*;
#(
    parameter int ROUND_TICKS   = 64,
    parameter int HOLD_CYCLES   = 8,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    localparam int TW = $clog2(ROUND_TICKS + 1),
    localparam int CW = $clog2(MAX_ROUNDS + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [1:0]    player1_health,
    input  logic [1:0]    player2_health,
    output logic          round_reset,
    output logic          round_active,
    output logic [TW-1:0] timer,
    output logic [1:0]    round_result,
    output logic [CW-1:0] p1_wins,
    output logic [CW-1:0] p2_wins,
    output logic [CW-1:0] rounds_played,
    output logic          match_over,
    output logic [1:0]    winner
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    result_q, result_d;
    logic [CW-1:0] p1_wins_q, p1_wins_d;
    logic [CW-1:0] p2_wins_q, p2_wins_d;
    logic [CW-1:0] rounds_q, rounds_d;
    logic [1:0]    winner_q, winner_d;

    logic          tmr_load;
    logic          tmr_en;
    logic          tmr_last;
    logic [TW-1:0] tmr_value;
    logic [1:0]    verdict;

    round_timer #(
        .W        (TW),
        .LOAD_VAL (ROUND_TICKS)
    ) u_round_timer (
        .clk   (CLK),
        .rst   (RST),
        .load  (tmr_load),
        .en    (tmr_en),
        .value (tmr_value),
        .last  (tmr_last)
    );

    // Round verdict for the current FIGHT cycle: KO outranks time-out.
    always_comb begin
        verdict = RES_NONE;
        if (player1_health == HEALTH_KO && player2_health == HEALTH_KO)
            verdict = RES_DRAW;
        else if (player1_health == HEALTH_KO)
            verdict = RES_P2;
        else if (player2_health == HEALTH_KO)
            verdict = RES_P1;
        else if (tmr_last)
            verdict = rank(int'(player1_health), int'(player2_health));
    end

    // Referee FSM next-state, scoring and timer control.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        result_d   = result_q;
        p1_wins_d  = p1_wins_q;
        p2_wins_d  = p2_wins_q;
        rounds_d   = rounds_q;
        winner_d   = winner_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        case (state_q)
            ST_IDLE, ST_MATCH_OVER: begin
                if (start) begin
                    state_d   = ST_START;
                    p1_wins_d = '0;
                    p2_wins_d = '0;
                    rounds_d  = '0;
                    winner_d  = RES_NONE;
                end
            end
            ST_START: begin
                tmr_load = 1'b1;
                result_d = RES_NONE;
                state_d  = ST_FIGHT;
            end
            ST_FIGHT: begin
                if (verdict != RES_NONE) begin
                    result_d   = verdict;
                    rounds_d   = rounds_q + CW'(1);
                    hold_cnt_d = '0;
                    state_d    = ST_HOLD;
                    if (verdict == RES_P1 && p1_wins_q < CW'(ROUNDS_TO_WIN))
                        p1_wins_d = p1_wins_q + CW'(1);
                    if (verdict == RES_P2 && p2_wins_q < CW'(ROUNDS_TO_WIN))
                        p2_wins_d = p2_wins_q + CW'(1);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                    if (p1_wins_q == CW'(ROUNDS_TO_WIN) || p2_wins_q == CW'(ROUNDS_TO_WIN) ||
                        rounds_q == CW'(MAX_ROUNDS)) begin
                        state_d  = ST_MATCH_OVER;
                        winner_d = rank(int'(p1_wins_q), int'(p2_wins_q));
                    end else begin
                        state_d = ST_START;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and scoring registers; reset returns everything to zero/IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            result_q   <= RES_NONE;
            p1_wins_q  <= '0;
            p2_wins_q  <= '0;
            rounds_q   <= '0;
            winner_q   <= RES_NONE;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            result_q   <= result_d;
            p1_wins_q  <= p1_wins_d;
            p2_wins_q  <= p2_wins_d;
            rounds_q   <= rounds_d;
            winner_q   <= winner_d;
        end
    end

    assign round_reset   = (state_q == ST_START);
    assign round_active  = (state_q == ST_FIGHT);
    assign match_over    = (state_q == ST_MATCH_OVER);
    assign timer         = tmr_value;
    assign round_result  = result_q;
    assign p1_wins       = p1_wins_q;
    assign p2_wins       = p2_wins_q;
    assign rounds_played = rounds_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_match_referee.sv
// tb/tb_match_referee.sv - randomized round-by-round bench for match_referee
module tb_match_referee;

    localparam int RT = 64;
    localparam int HC = 8;
    localparam int RW = 2;
    localparam int MR = 5;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic [1:0] player1_health;
    logic [1:0] player2_health;
    logic       round_reset;
    logic       round_active;
    logic [6:0] timer;
    logic [1:0] round_result;
    logic [2:0] p1_wins;
    logic [2:0] p2_wins;
    logic [2:0] rounds_played;
    logic       match_over;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_bad = 0;
    int m_p1, m_p2, m_rp;
    bit m_over;

    match_referee #(
        .ROUND_TICKS   (RT),
        .HOLD_CYCLES   (HC),
        .ROUNDS_TO_WIN (RW),
        .MAX_ROUNDS    (MR)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .start          (start),
        .player1_health (player1_health),
        .player2_health (player2_health),
        .round_reset    (round_reset),
        .round_active   (round_active),
        .timer          (timer),
        .round_result   (round_result),
        .p1_wins        (p1_wins),
        .p2_wins        (p2_wins),
        .rounds_played  (rounds_played),
        .match_over     (match_over),
        .winner         (winner)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [22:0] all_outs();
        return {round_reset, round_active, timer, round_result, p1_wins, p2_wins,
                rounds_played, match_over, winner};
    endfunction

    function automatic logic [1:0] nz();
        return 2'($urandom_range(1, 3));
    endfunction

    function automatic logic [1:0] better(input int a, input int b);
        if (a > b) return 2'b01;
        if (b > a) return 2'b10;
        return 2'b11;
    endfunction

    task automatic begin_match();
        start = 1'b1;
        n_cmp++;
        if (round_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL early_round_reset: got %0b expected 0", round_reset);
        end
        step();
        start = 1'b0;
        n_cmp++;
        if ({round_reset, match_over, p1_wins, p2_wins, rounds_played, winner} !== {1'b1, 1'b0, 11'd0}) begin
            n_bad++;
            $display("FAIL match_start: got rr=%0b mo=%0b p1=%0d p2=%0d rp=%0d win=%0d expected rr=1 rest 0",
                     round_reset, match_over, p1_wins, p2_wins, rounds_played, winner);
        end
        m_p1 = 0; m_p2 = 0; m_rp = 0; m_over = 0;
    endtask

    task automatic play_round(input int kind, input int ko_cyc, input logic [1:0] h1,
                              input logic [1:0] h2, input bit rand_start);
        int dec;
        logic [1:0] exp_res;
        n_cmp++;
        if (round_reset !== 1'b1 || round_active !== 1'b0) begin
            n_bad++;
            $display("FAIL start_cycle: got rr=%0b ra=%0b expected rr=1 ra=0", round_reset, round_active);
        end
        player1_health = 2'($urandom_range(0, 3));
        player2_health = 2'($urandom_range(0, 3));
        step();
        n_cmp++;
        if (round_active !== 1'b1 || timer !== 7'(RT)) begin
            n_bad++;
            $display("FAIL fight_entry: got ra=%0b timer=%0d expected ra=1 timer=%0d", round_active, timer, RT);
        end
        dec = (kind == 3) ? RT - 1 : ko_cyc;
        for (int i = 0; i <= dec; i++) begin
            if (kind == 3) begin
                player1_health = h1; player2_health = h2;
            end else if (i == dec) begin
                player1_health = (kind == 1) ? nz() : 2'd0;
                player2_health = (kind == 0) ? nz() : 2'd0;
            end else begin
                player1_health = nz(); player2_health = nz();
            end
            start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        start = 1'b0;
        case (kind)
            0: exp_res = 2'b10;
            1: exp_res = 2'b01;
            2: exp_res = 2'b11;
            default: exp_res = better(int'(h1), int'(h2));
        endcase
        m_rp++;
        if (exp_res == 2'b01 && m_p1 < RW) m_p1++;
        if (exp_res == 2'b10 && m_p2 < RW) m_p2++;
        n_cmp++;
        if (round_active !== 1'b0 || round_result !== exp_res) begin
            n_bad++;
            $display("FAIL round_result: got ra=%0b res=%0d expected ra=0 res=%0d", round_active, round_result, exp_res);
        end
        n_cmp++;
        if (p1_wins !== 3'(m_p1) || p2_wins !== 3'(m_p2) || rounds_played !== 3'(m_rp)) begin
            n_bad++;
            $display("FAIL score: got p1=%0d p2=%0d rp=%0d expected p1=%0d p2=%0d rp=%0d",
                     p1_wins, p2_wins, rounds_played, m_p1, m_p2, m_rp);
        end
        n_cmp++;
        if (timer !== 7'(RT - dec)) begin
            n_bad++;
            $display("FAIL timer_frozen: got %0d expected %0d", timer, RT - dec);
        end
        for (int j = 0; j < HC; j++) begin
            player1_health = 2'($urandom_range(0, 3));
            player2_health = 2'($urandom_range(0, 3));
            n_cmp++;
            if (round_result !== exp_res || round_reset !== 1'b0 || match_over !== 1'b0 ||
                timer !== 7'(RT - dec)) begin
                n_bad++;
                $display("FAIL hold_stable: got res=%0d rr=%0b mo=%0b timer=%0d at hold %0d expected res=%0d",
                         round_result, round_reset, match_over, timer, j, exp_res);
            end
            step();
        end
        m_over = (m_p1 == RW) || (m_p2 == RW) || (m_rp == MR);
        n_cmp++;
        if (m_over) begin
            if (match_over !== 1'b1 || round_reset !== 1'b0 || winner !== better(m_p1, m_p2)) begin
                n_bad++;
                $display("FAIL match_end: got mo=%0b rr=%0b win=%0d expected mo=1 rr=0 win=%0d",
                         match_over, round_reset, winner, better(m_p1, m_p2));
            end
        end else begin
            if (round_reset !== 1'b1 || match_over !== 1'b0) begin
                n_bad++;
                $display("FAIL next_round: got rr=%0b mo=%0b expected rr=1 mo=0", round_reset, match_over);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0;
        player1_health = 2'd3; player2_health = 2'd3;
        step(); step();
        n_cmp++;
        if (all_outs() !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %0h expected 0", all_outs());
        end
        RST = 1'b0;
        step();
        n_cmp++;
        if (all_outs() !== 23'd0) begin
            n_bad++;
            $display("FAIL idle_outputs: got %0h expected 0", all_outs());
        end
    endtask

    task automatic test_first_match();
        begin_match();
        play_round(1, 5, 2'd0, 2'd0, 1'b0);
        play_round(3, 0, 2'd2, 2'd2, 1'b0);
        play_round(2, $urandom_range(1, RT - 2), 2'd0, 2'd0, 1'b1);
        play_round(3, 0, 2'd2, 2'd1, 1'b0);
        for (int k = 0; k < 3; k++) step();
        n_cmp++;
        if (match_over !== 1'b1 || winner !== 2'b01 || p1_wins !== 3'd2) begin
            n_bad++;
            $display("FAIL match_over_hold: got mo=%0b win=%0d p1=%0d expected mo=1 win=1 p1=2",
                     match_over, winner, p1_wins);
        end
    endtask

    task automatic test_five_draws();
        begin_match();
        play_round(2, 0, 2'd0, 2'd0, 1'b0);
        for (int r = 1; r < MR; r++) begin
            logic [1:0] h;
            h = nz();
            if ($urandom_range(0, 1) == 0) play_round(2, $urandom_range(0, RT - 1), 2'd0, 2'd0, 1'b1);
            else play_round(3, 0, h, h, 1'b1);
        end
        n_cmp++;
        if (!m_over || rounds_played !== 3'd5 || winner !== 2'b11) begin
            n_bad++;
            $display("FAIL five_draws: got rp=%0d win=%0d expected rp=5 win=3", rounds_played, winner);
        end
    endtask

    task automatic test_random_matches();
        for (int m = 0; m < 4; m++) begin
            begin_match();
            if (m == 0) play_round(0, RT - 1, 2'd0, 2'd0, 1'b0);
            for (int r = 0; r < MR && !m_over; r++)
                play_round($urandom_range(0, 3), $urandom_range(0, RT - 1), nz(), nz(), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        begin_match();
        step();
        for (int k = 0; k < int'($urandom_range(1, 20)); k++) begin
            player1_health = nz(); player2_health = nz();
            step();
        end
        RST = 1'b1;
        step();
        n_cmp++;
        if (all_outs() !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_in_fight: got %0h expected 0", all_outs());
        end
        RST = 1'b0;
        step(); step();
        n_cmp++;
        if (all_outs() !== 23'd0) begin
            n_bad++;
            $display("FAIL after_reset_fight: got %0h expected 0", all_outs());
        end
        begin_match();
        step();
        player1_health = 2'd3; player2_health = 2'd0;
        step();
        for (int k = 0; k < 3; k++) begin
            player1_health = 2'($urandom_range(0, 3));
            player2_health = 2'($urandom_range(0, 3));
            step();
        end
        n_cmp++;
        if (round_result !== 2'b01 || p1_wins !== 3'd1) begin
            n_bad++;
            $display("FAIL hold_glitch: got res=%0d p1=%0d expected res=1 p1=1", round_result, p1_wins);
        end
        RST = 1'b1;
        step();
        n_cmp++;
        if (all_outs() !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_in_hold: got %0h expected 0", all_outs());
        end
        RST = 1'b0;
        step(); step();
        n_cmp++;
        if (all_outs() !== 23'd0) begin
            n_bad++;
            $display("FAIL after_reset_hold: got %0h expected 0", all_outs());
        end
    endtask

    initial begin
        test_reset();
        test_first_match();
        test_five_draws();
        test_random_matches();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
